// File: rtl/oled_text_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_text_pkg : shared constants and FSM encoding for the OLED    |
// | text scheduler.                                    Rev 1.0        |
// +------------------------------------------------------------------+
package oled_text_pkg;

   localparam int         c_NUM_LINES   = 4;
   localparam int         c_LINE_LEN    = 16;
   localparam logic [7:0] c_ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_SEND    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_GAP     = 3'd4
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/oled_text_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_text_if : writer ports plus the oled_controller byte link.   |
// | slave = scheduler side, master = application/controller side.     |
// |                                                    Rev 1.0        |
// +------------------------------------------------------------------+
interface oled_text_if #(
   parameter int ADDR_W = 6
);
   logic              wr_a_valid;
   logic [ADDR_W-1:0] wr_a_addr;
   logic [7:0]        wr_a_data;
   logic              wr_b_valid;
   logic [ADDR_W-1:0] wr_b_addr;
   logic [7:0]        wr_b_data;
   logic              wr_b_ready;
   logic [7:0]        sdin;
   logic              d_valid;
   logic              tx_done;
   logic              busy;
   logic              frame_done;

   modport slave (
      input  wr_a_valid, wr_a_addr, wr_a_data,
      input  wr_b_valid, wr_b_addr, wr_b_data,
      input  tx_done,
      output wr_b_ready, sdin, d_valid, busy, frame_done
   );

   modport master (
      output wr_a_valid, wr_a_addr, wr_a_data,
      output wr_b_valid, wr_b_addr, wr_b_data,
      output tx_done,
      input  wr_b_ready, sdin, d_valid, busy, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/oled_char_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_char_buffer : DEPTH x 8 character store, one write port,     |
// | one asynchronous read port, resets to spaces.      Rev 1.0        |
// +------------------------------------------------------------------+
module oled_char_buffer
   import oled_text_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= c_ASCII_SPACE;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/oled_text_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oled_text_scheduler : arbitrates two text writers into a frame    |
// | buffer and streams dirty frames to oled_controller.  Rev 1.0      |
// +------------------------------------------------------------------+
module oled_text_scheduler
   import oled_text_pkg::*;
#(
   parameter int NUM_LINES  = c_NUM_LINES,
   parameter int LINE_LEN   = c_LINE_LEN,
   parameter int GAP_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   oled_text_if.slave  bus
);

   localparam int c_DEPTH  = NUM_LINES * LINE_LEN;
   localparam int c_ADDR_W = $clog2(c_DEPTH);
   localparam int c_GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [c_ADDR_W:0]   c_DEPTH_V    = c_DEPTH[c_ADDR_W:0];
   localparam logic [c_ADDR_W-1:0] c_LAST_INDEX = c_ADDR_W'(c_DEPTH - 1);
   localparam logic [c_GAP_W-1:0]  c_GAP_INIT   = c_GAP_W'(GAP_CYCLES);

   sched_state_t        r_state,   w_state_nx;
   logic [c_ADDR_W-1:0] r_index,   w_index_nx;
   logic [c_GAP_W-1:0]  r_gap_cnt, w_gap_nx;
   logic [7:0]          r_sdin,    w_sdin_nx;
   logic                r_d_valid, w_d_valid_nx;
   logic                r_busy,    w_busy_nx;
   logic                r_frame_done, w_frame_done_nx;
   logic                r_dirty,   w_dirty_nx;
   logic                w_dirty_clr;

   logic                w_a_in_range, w_b_in_range;
   logic                w_a_wr, w_b_wr, w_wr_en;
   logic [c_ADDR_W-1:0] w_wr_addr;
   logic [7:0]          w_wr_data;
   logic [7:0]          w_rd_data;

   // Port A always wins; out-of-range addresses are dropped without marking dirty.
   assign w_a_in_range = ({1'b0, bus.wr_a_addr} < c_DEPTH_V);
   assign w_b_in_range = ({1'b0, bus.wr_b_addr} < c_DEPTH_V);
   assign w_a_wr       = bus.wr_a_valid && w_a_in_range;
   assign w_b_wr       = bus.wr_b_valid && !bus.wr_a_valid && w_b_in_range;
   assign w_wr_en      = w_a_wr || w_b_wr;
   assign w_wr_addr    = bus.wr_a_valid ? bus.wr_a_addr : bus.wr_b_addr;
   assign w_wr_data    = bus.wr_a_valid ? bus.wr_a_data : bus.wr_b_data;

   assign bus.wr_b_ready = !bus.wr_a_valid;

   oled_char_buffer #(
      .DEPTH  (c_DEPTH),
      .ADDR_W (c_ADDR_W)
   ) u_char_buffer (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (r_index),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_index      <= '0;
         r_gap_cnt    <= '0;
         r_sdin       <= 8'h00;
         r_d_valid    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_dirty      <= 1'b1;
      end else begin
         r_state      <= w_state_nx;
         r_index      <= w_index_nx;
         r_gap_cnt    <= w_gap_nx;
         r_sdin       <= w_sdin_nx;
         r_d_valid    <= w_d_valid_nx;
         r_busy       <= w_busy_nx;
         r_frame_done <= w_frame_done_nx;
         r_dirty      <= w_dirty_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_index_nx      = r_index;
      w_gap_nx        = r_gap_cnt;
      w_sdin_nx       = r_sdin;
      w_d_valid_nx    = r_d_valid;
      w_busy_nx       = r_busy;
      w_frame_done_nx = 1'b0;
      w_dirty_clr     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_dirty && !bus.tx_done) begin
               w_state_nx  = ST_FETCH;
               w_dirty_clr = 1'b1;
               w_index_nx  = '0;
               w_busy_nx   = 1'b1;
            end
         end
         ST_FETCH: begin
            w_sdin_nx    = w_rd_data;
            w_d_valid_nx = 1'b1;
            w_state_nx   = ST_SEND;
         end
         ST_SEND: begin
            if (bus.tx_done) begin
               w_d_valid_nx = 1'b0;
               w_state_nx   = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            // Wait for the controller to drop tx_done before presenting the next byte.
            if (!bus.tx_done) begin
               if (r_index == c_LAST_INDEX) begin
                  w_frame_done_nx = 1'b1;
                  w_busy_nx       = 1'b0;
                  w_index_nx      = '0;
                  w_gap_nx        = c_GAP_INIT;
                  w_state_nx      = ST_GAP;
               end else begin
                  w_index_nx = r_index + c_ADDR_W'(1);
                  w_state_nx = ST_FETCH;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_gap_nx = r_gap_cnt - c_GAP_W'(1);
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // A write landing on the same edge as the frame-start clear keeps dirty set.
   assign w_dirty_nx = w_wr_en ? 1'b1 : (w_dirty_clr ? 1'b0 : r_dirty);

   assign bus.sdin       = r_sdin;
   assign bus.d_valid    = r_d_valid;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_text_scheduler.sv
`default_nettype none
// Bench for oled_text_scheduler: behavioural buffer/frame model, controller
// responder for tx_done, directed scenarios followed by random writes.
module tb_oled_text_scheduler;

   localparam int NL    = 4;
   localparam int LL    = 16;
   localparam int GAP   = 0;
   localparam int DEPTH = NL * LL;
   localparam int AW    = 6;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   oled_text_if #(.ADDR_W(AW)) bus ();

   oled_text_scheduler #(
      .NUM_LINES  (NL),
      .LINE_LEN   (LL),
      .GAP_CYCLES (GAP)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference buffer: what the frame store holds after each edge, plus a
   // snapshot of its contents just before the most recent edge.
   int         cyc = 0;
   logic [7:0] mbuf [DEPTH];
   logic [7:0] pbuf [DEPTH];
   int         wq[$];

   always @(posedge clock) begin
      cyc++;
      pbuf = mbuf;
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) mbuf[k] = 8'h20;
         pbuf = mbuf;
         wq.delete();
      end else if (bus.wr_a_valid) begin
         if (int'(bus.wr_a_addr) < DEPTH) begin
            mbuf[bus.wr_a_addr] = bus.wr_a_data;
            wq.push_back(cyc);
         end
      end else if (bus.wr_b_valid) begin
         if (int'(bus.wr_b_addr) < DEPTH) begin
            mbuf[bus.wr_b_addr] = bus.wr_b_data;
            wq.push_back(cyc);
         end
      end
   end

   // Frame tracker, handshake checks and oled_controller responder.
   int         byte_cnt = 0;
   bit         in_frame = 0;
   bit         rst_pend = 1;
   int         prev_s   = -1;
   logic       prev_dv  = 0;
   logic [7:0] prev_sdin = 0;
   logic       txd_h1 = 0, txd_h2 = 0;
   logic [7:0] cur_frame  [DEPTH];
   logic [7:0] last_frame [DEPTH];
   int         frames    = 0;
   int         idle_wait = 0;
   int         quiet_cnt = 0;
   int         delay_cnt = 0;
   int         hold_cnt  = 0;
   bit         hold_req  = 0;
   bit         ctl_rnd   = 0;
   int         s_edge;
   bit         cause_ok;
   bit         pending;

   always @(negedge clock) begin
      if (!reset_n) begin
         byte_cnt  = 0;  in_frame = 0;  rst_pend = 1;  prev_s = -1;
         prev_dv   = 0;  prev_sdin = 0; txd_h1 = 0;    txd_h2 = 0;
         idle_wait = 0;  quiet_cnt = 0; delay_cnt = 0; hold_cnt = 0;
         bus.tx_done = 1'b0;
      end else begin
         if (prev_dv && txd_h1) begin
            chk(bus.d_valid == 1'b0, "dv_drop_after_txdone", bus.d_valid, 0);
         end else if (prev_dv) begin
            chk(bus.d_valid == 1'b1, "dv_held", bus.d_valid, 1);
            chk(bus.sdin == prev_sdin, "sdin_stable", bus.sdin, prev_sdin);
         end else if (bus.d_valid) begin
            chk(txd_h2 == 1'b0, "present_after_txdone_low", txd_h2, 0);
            if (!in_frame) begin
               s_edge   = cyc - 1;
               cause_ok = rst_pend;
               foreach (wq[k]) if (wq[k] >= prev_s && wq[k] <= s_edge - 1) cause_ok = 1;
               chk(cause_ok, "frame_start_cause", s_edge, prev_s);
               rst_pend = 0;
               prev_s   = s_edge;
               in_frame = 1;
               byte_cnt = 0;
            end
            chk(byte_cnt < DEPTH, "frame_len", byte_cnt, DEPTH - 1);
            if (byte_cnt < DEPTH) begin
               chk(bus.sdin == pbuf[byte_cnt], "byte_value", bus.sdin, pbuf[byte_cnt]);
               cur_frame[byte_cnt] = bus.sdin;
            end
            byte_cnt++;
         end

         if (bus.d_valid) chk(bus.busy == 1'b1, "busy_during_byte", bus.busy, 1);

         if (bus.frame_done) begin
            chk(in_frame && byte_cnt == DEPTH && !bus.d_valid, "frame_done_position", byte_cnt, DEPTH);
            chk(bus.busy == 1'b0, "busy_at_frame_done", bus.busy, 0);
            last_frame = cur_frame;
            frames++;
            in_frame = 0;
            byte_cnt = 0;
         end

         pending = rst_pend || (wq.size() > 0 && wq[$] >= prev_s);
         if (!in_frame && pending) begin
            idle_wait++;
            chk(idle_wait <= GAP + 8, "follow_up_frame_start", idle_wait, GAP + 8);
         end else begin
            idle_wait = 0;
         end

         if (!in_frame && !pending && !bus.d_valid && !bus.busy) quiet_cnt++;
         else quiet_cnt = 0;

         if (hold_cnt > 0) begin
            bus.tx_done = 1'b1;
            hold_cnt--;
         end else if (bus.d_valid && !bus.tx_done) begin
            if (delay_cnt > 0) delay_cnt--;
            else begin
               bus.tx_done = 1'b1;
               if (hold_req && byte_cnt == 4) begin
                  hold_cnt = 20;
                  hold_req = 0;
               end
               delay_cnt = ctl_rnd ? int'($urandom_range(0, 3)) : 0;
            end
         end else if (!bus.d_valid && bus.tx_done) begin
            if (delay_cnt > 0) delay_cnt--;
            else begin
               bus.tx_done = 1'b0;
               delay_cnt = ctl_rnd ? int'($urandom_range(0, 3)) : 0;
            end
         end
      end
      txd_h2    = txd_h1;
      txd_h1    = bus.tx_done;
      prev_dv   = bus.d_valid;
      prev_sdin = bus.sdin;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_a(input int addr, input logic [7:0] d);
      bus.wr_a_valid = 1'b1;
      bus.wr_a_addr  = AW'(addr);
      bus.wr_a_data  = d;
      step();
      bus.wr_a_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string nm);
      int i = 0;
      while (frames < target && i < 3000) begin
         step();
         i++;
      end
      chk(frames >= target, nm, frames, target);
   endtask

   task automatic wait_quiet(input string nm);
      int i = 0;
      step();
      step();
      while (quiet_cnt < 20 && i < 4000) begin
         step();
         i++;
      end
      chk(quiet_cnt >= 20, nm, quiet_cnt, 20);
   endtask

   task automatic wait_byte(input int cnt, input string nm);
      int i = 0;
      while (!(in_frame && byte_cnt == cnt && bus.d_valid) && i < 3000) begin
         step();
         i++;
      end
      chk(in_frame && byte_cnt == cnt, nm, byte_cnt, cnt);
   endtask

   int f0;
   int nmis;

   initial begin
      bus.wr_a_valid = 1'b0; bus.wr_a_addr = '0; bus.wr_a_data = 8'h00;
      bus.wr_b_valid = 1'b0; bus.wr_b_addr = '0; bus.wr_b_data = 8'h00;

      repeat (3) step();
      chk(bus.d_valid == 1'b0, "reset_d_valid", bus.d_valid, 0);
      chk(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
      chk(bus.frame_done == 1'b0, "reset_frame_done", bus.frame_done, 0);
      chk(bus.sdin == 8'h00, "reset_sdin", bus.sdin, 8'h00);
      chk(bus.wr_b_ready == 1'b1, "reset_b_ready", bus.wr_b_ready, 1);
      reset_n = 1'b1;

      // Blank frame after reset.
      wait_frames(1, "first_frame_timeout");
      nmis = 0;
      for (int k = 0; k < DEPTH; k++) if (last_frame[k] != 8'h20) nmis++;
      chk(nmis == 0, "blank_frame_after_reset", nmis, 0);
      wait_quiet("quiet_after_first");
      chk(bus.d_valid == 1'b0 && bus.busy == 1'b0, "idle_after_first", {bus.d_valid, bus.busy}, 0);

      // Single port A write.
      write_a(17, 8'h58);
      wait_quiet("quiet_after_a17");
      chk(last_frame[17] == 8'h58, "a17_value", last_frame[17], 8'h58);
      chk(last_frame[16] == 8'h20, "a16_value", last_frame[16], 8'h20);

      // Simultaneous A and B; B holds its request.
      bus.wr_a_valid = 1'b1; bus.wr_a_addr = 6'd0; bus.wr_a_data = 8'h41;
      bus.wr_b_valid = 1'b1; bus.wr_b_addr = 6'd1; bus.wr_b_data = 8'h42;
      #1;
      chk(bus.wr_b_ready == 1'b0, "b_ready_blocked", bus.wr_b_ready, 0);
      step();
      bus.wr_a_valid = 1'b0;
      #1;
      chk(bus.wr_b_ready == 1'b1, "b_ready_free", bus.wr_b_ready, 1);
      step();
      bus.wr_b_valid = 1'b0;
      wait_quiet("quiet_after_ab");
      chk(last_frame[0] == 8'h41, "ab_addr0", last_frame[0], 8'h41);
      chk(last_frame[1] == 8'h42, "ab_addr1", last_frame[1], 8'h42);

      // Mid-frame write behind the index.
      write_a(40, 8'h51);
      wait_byte(11, "reach_byte10");
      f0 = frames;
      write_a(5, 8'h5A);
      wait_frames(f0 + 1, "midframe_first_timeout");
      chk(last_frame[5] == 8'h20, "midframe_old_5", last_frame[5], 8'h20);
      chk(last_frame[40] == 8'h51, "midframe_40", last_frame[40], 8'h51);
      wait_frames(f0 + 2, "midframe_second_timeout");
      chk(last_frame[5] == 8'h5A, "midframe_new_5", last_frame[5], 8'h5A);
      wait_quiet("quiet_after_midframe");

      // tx_done held high after byte 3.
      hold_req = 1;
      write_a(62, 8'h48);
      wait_quiet("quiet_after_hold");
      chk(hold_req == 1'b0, "hold_applied", hold_req, 0);
      chk(last_frame[62] == 8'h48, "hold_frame_62", last_frame[62], 8'h48);
      chk(last_frame[3] == 8'h20, "hold_frame_3", last_frame[3], 8'h20);

      // Asynchronous reset in the middle of a frame.
      write_a(50, 8'h33);
      wait_byte(31, "reach_byte30");
      #2;
      reset_n = 1'b0;
      #1;
      chk(bus.d_valid == 1'b0, "async_rst_d_valid", bus.d_valid, 0);
      chk(bus.busy == 1'b0, "async_rst_busy", bus.busy, 0);
      chk(bus.sdin == 8'h00, "async_rst_sdin", bus.sdin, 8'h00);
      repeat (3) step();
      reset_n = 1'b1;
      f0 = frames;
      wait_frames(f0 + 1, "frame_after_reset_timeout");
      nmis = 0;
      for (int k = 0; k < DEPTH; k++) if (last_frame[k] != 8'h20) nmis++;
      chk(nmis == 0, "blank_after_mid_reset", nmis, 0);
      wait_quiet("quiet_after_mid_reset");

      // Random writers against a random-latency controller.
      ctl_rnd = 1;
      for (int i = 0; i < 400; i++) begin
         if (!(bus.wr_b_valid && bus.wr_a_valid)) begin
            bus.wr_b_valid = ($urandom_range(0, 2) == 0);
            bus.wr_b_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_b_data  = 8'($urandom_range(33, 126));
         end
         bus.wr_a_valid = ($urandom_range(0, 3) == 0);
         bus.wr_a_addr  = AW'($urandom_range(0, DEPTH - 1));
         bus.wr_a_data  = 8'($urandom_range(33, 126));
         #1;
         chk(bus.wr_b_ready == !bus.wr_a_valid, "b_ready_random", bus.wr_b_ready, !bus.wr_a_valid);
         step();
      end
      bus.wr_a_valid = 1'b0;
      bus.wr_b_valid = 1'b0;
      wait_quiet("quiet_after_random");
      nmis = 0;
      for (int k = 0; k < DEPTH; k++) if (last_frame[k] != mbuf[k]) nmis++;
      chk(nmis == 0, "final_frame_matches_buffer", nmis, 0);
      chk(bus.d_valid == 1'b0 && bus.busy == 1'b0, "idle_at_end", {bus.d_valid, bus.busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
